instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

- Produces the instruction stream consumed by the opcode decoder, driving `OpCode` on the decoder's input side.
- Holds the program counter and issues synchronous reads to instruction memory.
- Buffers returned words in a 2-entry queue and presents them with a valid/ready handshake.
- Accepts branch/jump redirects from the execute stage, discarding stale fetches.

## Interface
Parameters:
- ADDR_WIDTH, 10, instruction-memory word-address width; PC wraps modulo 2^ADDR_WIDTH words.
- RESET_PC, 0, word address fetched first after reset.

Ports:
- Clk  in  1  rising-edge clock.
- Rst  in  1  synchronous, active-high reset.
- ImemRdEn  out  1  read strobe; memory returns data the next cycle.
- ImemAddr  out  ADDR_WIDTH  word address for the read.
- ImemData  in  32  read data, valid the cycle after ImemRdEn.
- IssueValid  out  1  head instruction available.
- IssueReady  in  1  consumer accepts the head when high together with IssueValid.
- Instruction  out  32  head instruction word.
- OpCode  out  6  Instruction[31:26], to the decoder.
- PCPlus4  out  32  byte address of the head instruction + 4.
- Redirect  in  1  one-cycle request to change fetch address.
- RedirectTarget  in  32  byte address to fetch next.
- MisalignErr  out  1  sticky misaligned-redirect flag (see Configuration).

## Operation
- States: S_RESET, S_RUN, S_FLUSH, S_HALT.
- Transitions:
  - S_RESET -> S_RUN after one cycle.
  - S_RUN -> S_FLUSH on Redirect.
  - S_FLUSH -> S_RUN after one cycle.
  - S_HALT is left only by Rst.
- Read issue:
  - ImemRdEn = (state==S_RUN) && !Redirect && (count + inflight - pop) < 2.
  - count = queue occupancy; inflight = read issued last cycle and not dropped; pop = IssueValid && IssueReady.
  - The queue never overflows.
- PC:
  - ImemAddr = PC.
  - PC increments by 1 on each issued read.
  - All-ones wraps to 0.
- Queue:
  - Returned ImemData is written at the end of its arrival cycle.
  - The head drives Instruction/OpCode/PCPlus4.
  - PCPlus4 = zero-extend({word_addr,2'b00}) + 4, 32-bit.
- Redirect:
  - PC <= RedirectTarget[ADDR_WIDTH+1:2].
  - The queue is cleared.
  - The in-flight read, if any, has its data dropped.
- Redirect in the same cycle as a handshake: the handshake completes (consumer owns that word); all other entries are discarded.
- Redirect while in S_FLUSH: the newer target replaces PC; stays in S_FLUSH one more cycle.
- Simultaneous pop and write: both occur; count unchanged.

## Timing
- Reset values:
  - PC=RESET_PC, state=S_RESET, count=0.
  - IssueValid=0, ImemRdEn=0, Instruction=0, OpCode=0, PCPlus4=0, MisalignErr=0.
- Rst mid-operation discards queue and in-flight data; its effect is visible the cycle after it is sampled.
- Cycle 0 = first cycle with Rst low:
  - Cycle 1: ImemRdEn=1, ImemAddr=RESET_PC.
  - Cycle 2: data returns.
  - Cycle 3: IssueValid=1.
- Fetch-to-issue latency: 2 cycles from ImemRdEn to IssueValid.
- Throughput: one instruction per cycle while IssueReady is held high.
- Redirect sampled in cycle t:
  - Cycle t+1: IssueValid=0, state S_FLUSH.
  - Cycle t+2: ImemRdEn=1 at the target.
  - Cycle t+4: target instruction presented.
- Stall: when IssueReady is low, the head and all outputs hold stable; reads stop once count + inflight reaches 2.

## Configuration
- FETCH_MISALIGN_CHECK_EN defined:
  - A Redirect with RedirectTarget[1:0] != 0 sets MisalignErr=1 (sticky).
  - Queue and in-flight data are discarded and the block enters S_HALT.
  - In S_HALT, IssueValid=0 and ImemRdEn=0 until Rst.
- Not defined:
  - RedirectTarget[1:0] is ignored (truncated).
  - MisalignErr is tied 0; S_HALT is unreachable.

## Test plan
- Reset, memory word n = 0x20000000+n, IssueReady=1 -> first IssueValid at cycle 3 with Instruction=0x20000000, OpCode=0x08, PCPlus4=4; then one word per cycle, PCPlus4 stepping by 4.
- IssueReady low for cycles 3-9 -> Instruction holds 0x20000000, ImemRdEn drops after 2 outstanding, no word lost or duplicated after release.
- Redirect to 0x40 in the cycle word 2 is accepted -> word 2 handshake completes, words 3-4 never issued, next issued word is at word 16 with PCPlus4=0x44, at t+4.
- ADDR_WIDTH=4, run past word 15 -> ImemAddr wraps 15 -> 0, PCPlus4 sequence 0x40 then 0x4.
- Back-to-back Redirects to 0x80 then 0xC0 -> only 0xC0 stream issues; nothing from 0x80 appears.
- With FETCH_MISALIGN_CHECK_EN, Redirect to 0x42 -> MisalignErr=1 next cycle, IssueValid and ImemRdEn stay 0 until Rst. Without the macro -> fetch resumes at word 16.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
// Holds the program counter, issues synchronous instruction-memory reads and
// buffers returned words in a 2-entry queue presented with a valid/ready
// handshake. Redirects from execute reload the PC and discard stale fetches.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (misaligned redirect traps
// into a halt state with a sticky MisalignErr flag).

module instruction_fetch_unit #(
    parameter int          ADDR_WIDTH = 10,
    parameter int unsigned RESET_PC   = 0
) (
    input  logic                  Clk,
    input  logic                  Rst,
    output logic                  ImemRdEn,
    output logic [ADDR_WIDTH-1:0] ImemAddr,
    input  logic [31:0]           ImemData,
    output logic                  IssueValid,
    input  logic                  IssueReady,
    output logic [31:0]           Instruction,
    output logic [5:0]            OpCode,
    output logic [31:0]           PCPlus4,
    input  logic                  Redirect,
    input  logic [31:0]           RedirectTarget,
    output logic                  MisalignErr
);

    typedef enum logic [1:0] {S_RESET, S_RUN, S_FLUSH, S_HALT} state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  inflight;
    logic [ADDR_WIDTH-1:0] inflight_addr;
    logic [1:0]            count;
    logic [31:0]           q_data0;
    logic [31:0]           q_data1;
    logic [ADDR_WIDTH-1:0] q_addr0;
    logic [ADDR_WIDTH-1:0] q_addr1;

    logic                  issue_valid;
    logic                  rd_en;
    logic                  pop;
    logic [2:0]            occupancy;
    logic                  redirect_take;
    logic                  bad_target;
    logic                  write_en;

    // Handshake, read-issue decision and next-state decode
    always_comb begin
        state_next    = state;
        issue_valid   = 1'b0;
        rd_en         = 1'b0;
        pop           = 1'b0;
        occupancy     = 3'd0;
        redirect_take = 1'b0;
        bad_target    = 1'b0;

        redirect_take = Redirect && ((state == S_RUN) || (state == S_FLUSH));
`ifdef FETCH_MISALIGN_CHECK_EN
        bad_target = redirect_take && (RedirectTarget[1:0] != 2'b00);
`endif
        issue_valid = (state == S_RUN) && (count != 2'd0);
        pop         = issue_valid && IssueReady;
        occupancy   = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
        rd_en       = (state == S_RUN) && !Redirect && (occupancy < 3'd2);

        case (state)
            S_RESET: state_next = S_RUN;
            S_RUN: begin
                if (bad_target)
                    state_next = S_HALT;
                else if (Redirect)
                    state_next = S_FLUSH;
            end
            S_FLUSH: begin
                if (bad_target)
                    state_next = S_HALT;
                else if (!Redirect)
                    state_next = S_RUN;
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_RESET;
        endcase
    end

    // Returning data is dropped when a redirect lands in its arrival cycle
    assign write_en = inflight && !redirect_take;

    assign IssueValid  = issue_valid;
    assign ImemRdEn    = rd_en;
    assign ImemAddr    = pc;
    assign Instruction = issue_valid ? q_data0 : 32'd0;
    assign OpCode      = Instruction[31:26];
    assign PCPlus4     = issue_valid ? ({{(30-ADDR_WIDTH){1'b0}}, q_addr0, 2'b00} + 32'd4) : 32'd0;

    // State register
    always_ff @(posedge Clk) begin
        if (Rst)
            state <= S_RESET;
        else
            state <= state_next;
    end

    // Program counter and the single outstanding memory read
    always_ff @(posedge Clk) begin
        if (Rst) begin
            pc            <= ADDR_WIDTH'(RESET_PC);
            inflight      <= 1'b0;
            inflight_addr <= '0;
        end else begin
            if (redirect_take)
                pc <= RedirectTarget[ADDR_WIDTH+1:2];
            else if (rd_en)
                pc <= pc + ADDR_WIDTH'(1);
            inflight <= rd_en;
            if (rd_en)
                inflight_addr <= pc;
        end
    end

    // Two-entry issue queue, entry 0 is the head; a redirect keeps only the
    // word handed over in the same cycle, which has already left the queue
    always_ff @(posedge Clk) begin
        if (Rst) begin
            count   <= 2'd0;
            q_data0 <= 32'd0;
            q_data1 <= 32'd0;
            q_addr0 <= '0;
            q_addr1 <= '0;
        end else if (redirect_take) begin
            count <= 2'd0;
        end else if (pop && write_en) begin
            if (count == 2'd2) begin
                q_data0 <= q_data1;
                q_addr0 <= q_addr1;
                q_data1 <= ImemData;
                q_addr1 <= inflight_addr;
            end else begin
                q_data0 <= ImemData;
                q_addr0 <= inflight_addr;
            end
        end else if (pop) begin
            q_data0 <= q_data1;
            q_addr0 <= q_addr1;
            count   <= count - 2'd1;
        end else if (write_en) begin
            if (count == 2'd0) begin
                q_data0 <= ImemData;
                q_addr0 <= inflight_addr;
            end else begin
                q_data1 <= ImemData;
                q_addr1 <= inflight_addr;
            end
            count <= count + 2'd1;
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign;
    logic unused_target_bits;

    // Sticky misaligned-redirect flag, cleared only by reset
    always_ff @(posedge Clk) begin
        if (Rst)
            misalign <= 1'b0;
        else if (bad_target)
            misalign <= 1'b1;
    end

    assign MisalignErr        = misalign;
    assign unused_target_bits = ^RedirectTarget[31:ADDR_WIDTH+2];
`else
    logic unused_target_bits;

    assign MisalignErr        = 1'b0;
    assign unused_target_bits = ^{RedirectTarget[31:ADDR_WIDTH+2], RedirectTarget[1:0]};
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit
// Self-checking bench: table-driven startup/stall vectors, hand-written
// redirect sequences, and a scoreboard of expected issued words.
// Honours FETCH_MISALIGN_CHECK_EN for the misaligned-redirect sequence.

module tb_instruction_fetch_unit;

    localparam int AW = 10;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          ImemRdEn;
    logic [AW-1:0] ImemAddr;
    logic [31:0]   ImemData = 32'd0;
    logic          IssueValid;
    logic          IssueReady;
    logic [31:0]   Instruction;
    logic [5:0]    OpCode;
    logic [31:0]   PCPlus4;
    logic          Redirect;
    logic [31:0]   RedirectTarget;
    logic          MisalignErr;

    int n_compared   = 0;
    int n_mismatched = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pcp;
    } exp_t;

    exp_t exp_q[$];

    typedef struct {
        bit rst_before;
        bit ready;
        bit exp_rden;
        int exp_addr;
        bit exp_valid;
        int exp_word;
    } vec_t;

    vec_t vecs[19];

    instruction_fetch_unit #(.ADDR_WIDTH(AW), .RESET_PC(0)) dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .ImemRdEn       (ImemRdEn),
        .ImemAddr       (ImemAddr),
        .ImemData       (ImemData),
        .IssueValid     (IssueValid),
        .IssueReady     (IssueReady),
        .Instruction    (Instruction),
        .OpCode         (OpCode),
        .PCPlus4        (PCPlus4),
        .Redirect       (Redirect),
        .RedirectTarget (RedirectTarget),
        .MisalignErr    (MisalignErr)
    );

    initial forever #5 Clk = ~Clk;

    // Instruction memory: word n holds 0x20000000 + n, one-cycle read latency
    always @(posedge Clk) begin
        if (ImemRdEn === 1'b1)
            ImemData <= 32'h2000_0000 + 32'(ImemAddr);
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic pushWords(input int first, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            int w;
            w       = (first + i) % 1024;
            e.instr = 32'h2000_0000 + 32'(w);
            e.pcp   = 32'(w * 4 + 4);
            exp_q.push_back(e);
        end
    endtask

    // Scoreboard: every handshake must match the oldest expected word
    always @(negedge Clk) begin
        if (Rst === 1'b0 && IssueValid === 1'b1 && IssueReady === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_compared++;
                n_mismatched++;
                $display("[TB] FAIL sb_unexpected: got word 0x%08h, expected no issue", Instruction);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("sb_instr", Instruction, e.instr);
                checkOutput("sb_opcode", 32'(OpCode), 32'(e.instr[31:26]));
                checkOutput("sb_pcplus4", PCPlus4, e.pcp);
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Hold reset two cycles, check reset values, release and expect a fresh stream
    task automatic doReset(input int n_words);
        Rst            = 1'b1;
        IssueReady     = 1'b0;
        Redirect       = 1'b0;
        RedirectTarget = 32'd0;
        step();
        exp_q.delete();
        @(negedge Clk);
        checkOutput("rst_valid", 32'(IssueValid), 32'd0);
        checkOutput("rst_rden", 32'(ImemRdEn), 32'd0);
        checkOutput("rst_addr", 32'(ImemAddr), 32'd0);
        checkOutput("rst_instr", Instruction, 32'd0);
        checkOutput("rst_opcode", 32'(OpCode), 32'd0);
        checkOutput("rst_pcplus4", PCPlus4, 32'd0);
        checkOutput("rst_misalign", 32'(MisalignErr), 32'd0);
        step();
        Rst = 1'b0;
        pushWords(0, n_words);
    endtask

    // Consume until every expected word has been issued, then stop accepting
    task automatic drain();
        IssueReady = 1'b1;
        for (int k = 0; k < 64; k++) begin
            step();
            if (exp_q.size() == 0) begin
                IssueReady = 1'b0;
                return;
            end
        end
        checkOutput("drain_timeout", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        IssueReady = 1'b0;
    endtask

    // Redirect with the consumer idle, then follow the target stream
    task automatic redirectTo(input logic [31:0] target);
        int w;
        w              = int'(target[AW+1:2]);
        IssueReady     = 1'b0;
        Redirect       = 1'b1;
        RedirectTarget = target;
        pushWords(w, 4);
        @(negedge Clk);
        checkOutput("redir_t0_rden", 32'(ImemRdEn), 32'd0);
        step();
        Redirect   = 1'b0;
        IssueReady = 1'b1;
        @(negedge Clk);
        checkOutput("redir_t1_valid", 32'(IssueValid), 32'd0);
        checkOutput("redir_t1_misalign", 32'(MisalignErr), 32'd0);
        step();
        @(negedge Clk);
        checkOutput("redir_t2_rden", 32'(ImemRdEn), 32'd1);
        checkOutput("redir_t2_addr", 32'(ImemAddr), 32'(w));
        step();
        @(negedge Clk);
        checkOutput("redir_t3_addr", 32'(ImemAddr), 32'((w + 1) % 1024));
        step();
        @(negedge Clk);
        checkOutput("redir_t4_valid", 32'(IssueValid), 32'd1);
        checkOutput("redir_t4_instr", Instruction, 32'h2000_0000 + 32'(w));
        checkOutput("redir_t4_pcplus4", PCPlus4, 32'(w * 4 + 4));
        checkOutput("redir_t4_addr", 32'(ImemAddr), 32'((w + 2) % 1024));
        drain();
    endtask

    function automatic vec_t mk(bit rst, bit rdy, bit rden, int addr, bit v, int word);
        vec_t r;
        r.rst_before = rst;
        r.ready      = rdy;
        r.exp_rden   = rden;
        r.exp_addr   = addr;
        r.exp_valid  = v;
        r.exp_word   = word;
        return r;
    endfunction

    // Applies one table row per cycle and compares the cycle's outputs
    task automatic applyStimulus();
        for (int i = 0; i < 19; i++) begin
            logic [31:0] ei;
            if (vecs[i].rst_before)
                doReset(16);
            IssueReady = vecs[i].ready;
            ei = 32'h2000_0000 + 32'(vecs[i].exp_word);
            @(negedge Clk);
            checkOutput($sformatf("v%0d_rden", i), 32'(ImemRdEn), 32'(vecs[i].exp_rden));
            if (vecs[i].exp_rden)
                checkOutput($sformatf("v%0d_addr", i), 32'(ImemAddr), 32'(vecs[i].exp_addr));
            checkOutput($sformatf("v%0d_valid", i), 32'(IssueValid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                checkOutput($sformatf("v%0d_instr", i), Instruction, ei);
                checkOutput($sformatf("v%0d_opcode", i), 32'(OpCode), 32'(ei[31:26]));
                checkOutput($sformatf("v%0d_pcplus4", i), PCPlus4, 32'(vecs[i].exp_word * 4 + 4));
            end
            step();
        end
    endtask

    initial begin
        // Startup with consumer always ready: cycles 0..5 after reset
        vecs[0]  = mk(1, 1, 0, 0, 0, 0);
        vecs[1]  = mk(0, 1, 1, 0, 0, 0);
        vecs[2]  = mk(0, 1, 1, 1, 0, 0);
        vecs[3]  = mk(0, 1, 1, 2, 1, 0);
        vecs[4]  = mk(0, 1, 1, 3, 1, 1);
        vecs[5]  = mk(0, 1, 1, 4, 1, 2);
        // Consumer stalls over cycles 3..9, then resumes
        vecs[6]  = mk(1, 1, 0, 0, 0, 0);
        vecs[7]  = mk(0, 1, 1, 0, 0, 0);
        vecs[8]  = mk(0, 1, 1, 1, 0, 0);
        vecs[9]  = mk(0, 0, 0, 0, 1, 0);
        vecs[10] = mk(0, 0, 0, 0, 1, 0);
        vecs[11] = mk(0, 0, 0, 0, 1, 0);
        vecs[12] = mk(0, 0, 0, 0, 1, 0);
        vecs[13] = mk(0, 0, 0, 0, 1, 0);
        vecs[14] = mk(0, 0, 0, 0, 1, 0);
        vecs[15] = mk(0, 0, 0, 0, 1, 0);
        vecs[16] = mk(0, 1, 1, 2, 1, 0);
        vecs[17] = mk(0, 1, 1, 3, 1, 1);
        vecs[18] = mk(0, 1, 1, 4, 1, 2);

        applyStimulus();

        // Redirect to 0x40 in the same cycle word 2 is handed over
        doReset(3);
        IssueReady = 1'b1;
        repeat (5) step();
        Redirect       = 1'b1;
        RedirectTarget = 32'h0000_0040;
        pushWords(16, 4);
        @(negedge Clk);
        checkOutput("hs_redir_valid", 32'(IssueValid), 32'd1);
        checkOutput("hs_redir_instr", Instruction, 32'h2000_0002);
        checkOutput("hs_redir_rden", 32'(ImemRdEn), 32'd0);
        step();
        Redirect = 1'b0;
        @(negedge Clk);
        checkOutput("hs_t1_valid", 32'(IssueValid), 32'd0);
        checkOutput("hs_t1_rden", 32'(ImemRdEn), 32'd0);
        step();
        @(negedge Clk);
        checkOutput("hs_t2_rden", 32'(ImemRdEn), 32'd1);
        checkOutput("hs_t2_addr", 32'(ImemAddr), 32'd16);
        step();
        @(negedge Clk);
        checkOutput("hs_t3_valid", 32'(IssueValid), 32'd0);
        step();
        @(negedge Clk);
        checkOutput("hs_t4_valid", 32'(IssueValid), 32'd1);
        checkOutput("hs_t4_instr", Instruction, 32'h2000_0010);
        checkOutput("hs_t4_pcplus4", PCPlus4, 32'h0000_0044);
        drain();

        // Fetch across the top of the address space: words 1022, 1023, 0, 1
        redirectTo(32'h0000_0FF8);

        // Back-to-back redirects: only the 0xC0 stream may issue
        IssueReady     = 1'b0;
        Redirect       = 1'b1;
        RedirectTarget = 32'h0000_0080;
        @(negedge Clk);
        checkOutput("b2b_t0_rden", 32'(ImemRdEn), 32'd0);
        step();
        RedirectTarget = 32'h0000_00C0;
        pushWords(48, 4);
        @(negedge Clk);
        checkOutput("b2b_t1_valid", 32'(IssueValid), 32'd0);
        checkOutput("b2b_t1_rden", 32'(ImemRdEn), 32'd0);
        step();
        Redirect   = 1'b0;
        IssueReady = 1'b1;
        @(negedge Clk);
        checkOutput("b2b_t2_rden", 32'(ImemRdEn), 32'd0);
        step();
        @(negedge Clk);
        checkOutput("b2b_t3_rden", 32'(ImemRdEn), 32'd1);
        checkOutput("b2b_t3_addr", 32'(ImemAddr), 32'd48);
        step();
        step();
        @(negedge Clk);
        checkOutput("b2b_t5_valid", 32'(IssueValid), 32'd1);
        checkOutput("b2b_t5_instr", Instruction, 32'h2000_0030);
        checkOutput("b2b_t5_pcplus4", PCPlus4, 32'h0000_00C4);
        drain();

        // Misaligned redirect target 0x42
`ifdef FETCH_MISALIGN_CHECK_EN
        IssueReady     = 1'b0;
        Redirect       = 1'b1;
        RedirectTarget = 32'h0000_0042;
        step();
        Redirect   = 1'b0;
        IssueReady = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge Clk);
            checkOutput($sformatf("mis_c%0d_flag", k), 32'(MisalignErr), 32'd1);
            checkOutput($sformatf("mis_c%0d_valid", k), 32'(IssueValid), 32'd0);
            checkOutput($sformatf("mis_c%0d_rden", k), 32'(ImemRdEn), 32'd0);
            step();
        end
        doReset(2);
        drain();
`else
        redirectTo(32'h0000_0042);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
